// File: rtl/ffa_pkg.sv
// ============================================================================
// ffa_pkg : shared types and grant helper for the ffa request controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package ffa_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE_WR = 2'd1,
      ISSUE_RD = 2'd2,
      RSP      = 2'd3
   } ffa_state_e;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } grant_e;

   localparam int unsigned C_WR_IDX = 0;
   localparam int unsigned C_RD_IDX = 1;

   // One-hot grant; on a tie the requester opposite the last winner is chosen.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input grant_e last);
      logic [1:0] g;
      g = 2'b00;
      case (req)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = (last == GNT_RD) ? 2'b01 : 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ffa_rr_arb2.sv
// ============================================================================
// ffa_rr_arb2 : two-requester round-robin arbiter (bit 0 = write, bit 1 = read)
// Revision: 1.0
// ============================================================================
`default_nettype none

module ffa_rr_arb2
   import ffa_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] req,
   input  logic       ack,
   output logic [1:0] gnt
);

   grant_e r_last_grant;

   always_comb begin
      gnt = rr_pick(req, r_last_grant);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_last_grant <= GNT_RD;
      end else if (ack && (gnt != 2'b00)) begin
         r_last_grant <= gnt[C_RD_IDX] ? GNT_RD : GNT_WR;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ffa_req_ctrl.sv
// ============================================================================
// ffa_req_ctrl : arbitrates write/read requests into single-cycle array strobes
//                and holds the captured read response until accepted
// Revision: 1.0
// ============================================================================
`default_nettype none

module ffa_req_ctrl
   import ffa_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int DATA_N = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              wr_req_valid,
   output logic              wr_req_ready,
   input  logic [ADDR_W-1:0] wr_req_addr,
   input  logic [DATA_W-1:0] wr_req_data,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  logic [ADDR_W-1:0] rd_req_addr,
   output logic              rd_rsp_valid,
   input  logic              rd_rsp_ready,
   output logic [DATA_W-1:0] rd_rsp_data,
   output logic              rd_rsp_err,
   output logic              ffa_wr,
   output logic              ffa_rd,
   output logic [ADDR_W-1:0] ffa_addr,
   output logic [DATA_W-1:0] ffa_din,
   input  logic [DATA_W-1:0] ffa_dout,
   input  logic              ffa_error,
   output logic              busy
);

   localparam logic [ADDR_W:0] C_DATA_N = DATA_N[ADDR_W:0];

   ffa_state_e        r_state;
   ffa_state_e        w_next_state;
   logic [1:0]        w_req;
   logic [1:0]        w_gnt;
   logic              w_idle;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_acc;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_din;
   logic              r_ffa_wr;
   logic              r_ffa_rd;
   logic [DATA_N-1:0] r_valid_map;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_err;
   logic              w_addr_ok;
   logic              w_map_bit;
   logic              w_rd_err;

   assign w_req = {rd_req_valid, wr_req_valid};

   ffa_rr_arb2 u_arb (
      .clk    (clk),
      .resetn (resetn),
      .req    (w_req),
      .ack    (w_acc),
      .gnt    (w_gnt)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_wr_acc) begin
               w_next_state = ISSUE_WR;
            end else if (w_rd_acc) begin
               w_next_state = ISSUE_RD;
            end
         end
         ISSUE_WR: w_next_state = IDLE;
         ISSUE_RD: w_next_state = RSP;
         RSP: begin
            if (rd_rsp_ready) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Readies are gated by resetn so nothing looks accepted while reset is held.
   always_comb begin
      w_idle       = resetn && (r_state == IDLE);
      wr_req_ready = w_idle && w_gnt[C_WR_IDX];
      rd_req_ready = w_idle && w_gnt[C_RD_IDX];
      w_wr_acc     = wr_req_valid && wr_req_ready;
      w_rd_acc     = rd_req_valid && rd_req_ready;
      w_acc        = w_wr_acc || w_rd_acc;
      busy         = (r_state != IDLE);
      rd_rsp_valid = (r_state == RSP);
   end

   always_comb begin
      w_addr_ok = ({1'b0, r_addr} < C_DATA_N);
      w_map_bit = w_addr_ok ? r_valid_map[r_addr] : 1'b0;
      w_rd_err  = ffa_error || !w_map_bit || !w_addr_ok;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_addr      <= '0;
         r_din       <= '0;
         r_ffa_wr    <= 1'b0;
         r_ffa_rd    <= 1'b0;
         r_valid_map <= '0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_ffa_wr <= w_wr_acc;
         r_ffa_rd <= w_rd_acc;
         if (w_wr_acc) begin
            r_addr <= wr_req_addr;
            r_din  <= wr_req_data;
         end else if (w_rd_acc) begin
            r_addr <= rd_req_addr;
         end
         if ((r_state == ISSUE_WR) && w_addr_ok) begin
            r_valid_map[r_addr] <= 1'b1;
         end
         // Array data is only valid during the read strobe, so it is captured here.
         if (r_state == ISSUE_RD) begin
            r_rsp_err  <= w_rd_err;
            r_rsp_data <= w_rd_err ? '0 : ffa_dout;
         end
      end
   end

   assign ffa_wr      = r_ffa_wr;
   assign ffa_rd      = r_ffa_rd;
   assign ffa_addr    = r_addr;
   assign ffa_din     = r_din;
   assign rd_rsp_data = r_rsp_data;
   assign rd_rsp_err  = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_ffa_req_ctrl.sv
// ============================================================================
// tb_ffa_req_ctrl : directed scoreboard bench for ffa_req_ctrl with an array model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ffa_req_ctrl;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int DATA_N = 8;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              err;
   } rsp_t;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              wr_req_valid = 1'b0;
   logic              wr_req_ready;
   logic [ADDR_W-1:0] wr_req_addr = '0;
   logic [DATA_W-1:0] wr_req_data = '0;
   logic              rd_req_valid = 1'b0;
   logic              rd_req_ready;
   logic [ADDR_W-1:0] rd_req_addr = '0;
   logic              rd_rsp_valid;
   logic              rd_rsp_ready = 1'b1;
   logic [DATA_W-1:0] rd_rsp_data;
   logic              rd_rsp_err;
   logic              ffa_wr;
   logic              ffa_rd;
   logic [ADDR_W-1:0] ffa_addr;
   logic [DATA_W-1:0] ffa_din;
   logic [DATA_W-1:0] ffa_dout;
   logic              ffa_error;
   logic              busy;

   logic [DATA_W-1:0] mem [DATA_N];
   logic              force_err = 1'b0;
   bit                written [DATA_N];
   logic [DATA_W-1:0] model_mem [DATA_N];
   rsp_t              exp_q [$];
   int                tests = 0;
   int                fails = 0;
   int                wr_strobes = 0;
   int                rd_strobes = 0;

   always #5 clk = ~clk;

   ffa_req_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DATA_N(DATA_N)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .wr_req_valid (wr_req_valid),
      .wr_req_ready (wr_req_ready),
      .wr_req_addr  (wr_req_addr),
      .wr_req_data  (wr_req_data),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rd_req_addr  (rd_req_addr),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_ready (rd_rsp_ready),
      .rd_rsp_data  (rd_rsp_data),
      .rd_rsp_err   (rd_rsp_err),
      .ffa_wr       (ffa_wr),
      .ffa_rd       (ffa_rd),
      .ffa_addr     (ffa_addr),
      .ffa_din      (ffa_din),
      .ffa_dout     (ffa_dout),
      .ffa_error    (ffa_error),
      .busy         (busy)
   );

   // Array model: combinational read, registered write; contents survive controller reset.
   assign ffa_dout  = ffa_rd ? mem[ffa_addr] : '0;
   assign ffa_error = ffa_rd & force_err;
   always @(posedge clk) if (ffa_wr) mem[ffa_addr] <= ffa_din;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic rsp_t model_rsp(input logic [ADDR_W-1:0] a);
      rsp_t r;
      r.err  = force_err || (int'(a) >= DATA_N) || !written[a];
      r.data = r.err ? '0 : model_mem[a];
      return r;
   endfunction

   // Monitor: strobe exclusivity, strobe counting, scoreboard pop on response handshake.
   always @(negedge clk) begin
      rsp_t e;
      if (ffa_wr) wr_strobes++;
      if (ffa_rd) rd_strobes++;
      if (ffa_wr || ffa_rd) check("strobe_exclusive", {31'd0, ffa_wr & ffa_rd}, 32'd0);
      if (resetn && rd_rsp_valid && rd_rsp_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: got data 0x%0h err %0b, expected no response", rd_rsp_data, rd_rsp_err);
         end else begin
            e = exp_q.pop_front();
            check("rsp_data", {24'd0, rd_rsp_data}, {24'd0, e.data});
            check("rsp_err", {31'd0, rd_rsp_err}, {31'd0, e.err});
         end
      end
   end

   task automatic wait_acc(input bit is_wr);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (is_wr ? wr_req_ready : rd_req_ready) begin
            ok = 1'b1;
            @(posedge clk);
            #1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got no ready in 20 cycles, expected ready (is_wr=%0b)", is_wr);
      end
   endtask

   task automatic issue_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_req_addr  = a;
      wr_req_data  = d;
      wr_req_valid = 1'b1;
      wait_acc(1'b1);
      wr_req_valid = 1'b0;
      if (int'(a) < DATA_N) begin
         written[a]   = 1'b1;
         model_mem[a] = d;
      end
   endtask

   task automatic issue_rd(input logic [ADDR_W-1:0] a, input bit expect_rsp);
      rd_req_addr  = a;
      rd_req_valid = 1'b1;
      wait_acc(1'b0);
      rd_req_valid = 1'b0;
      if (expect_rsp) exp_q.push_back(model_rsp(a));
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r0;
      int g;
      bit exp_wr;
      bit acc_wr;

      // Reset state, with a write request held to show readies stay low.
      wr_req_valid = 1'b1;
      idle_cycles(2);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ffa_wr", {31'd0, ffa_wr}, 32'd0);
      check("rst_ffa_rd", {31'd0, ffa_rd}, 32'd0);
      check("rst_rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
      check("rst_rsp_data", {24'd0, rd_rsp_data}, 32'd0);
      check("rst_wr_ready", {31'd0, wr_req_ready}, 32'd0);
      check("rst_ffa_addr", {29'd0, ffa_addr}, 32'd0);
      wr_req_valid = 1'b0;
      resetn = 1'b1;
      idle_cycles(1);

      // 1: write then read back with latency checks
      issue_wr(3'd3, 8'hA5);
      @(negedge clk);
      check("t1_wr_strobe", {31'd0, ffa_wr}, 32'd1);
      check("t1_wr_addr", {29'd0, ffa_addr}, 32'd3);
      check("t1_wr_din", {24'd0, ffa_din}, 32'hA5);
      check("t1_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("t1_wr_strobe_off", {31'd0, ffa_wr}, 32'd0);
      check("t1_idle_again", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      issue_rd(3'd3, 1'b1);
      @(negedge clk);
      check("t1_rd_strobe", {31'd0, ffa_rd}, 32'd1);
      check("t1_rd_addr", {29'd0, ffa_addr}, 32'd3);
      @(negedge clk);
      check("t1_rsp_valid_t2", {31'd0, rd_rsp_valid}, 32'd1);
      idle_cycles(2);

      // 2: unwritten address reads back as error, one strobe
      r0 = rd_strobes;
      issue_rd(3'd5, 1'b1);
      idle_cycles(4);
      check("t2_rd_pulses", rd_strobes - r0, 32'd1);

      // 3: both channels valid every cycle; last winner was RD so WR goes first
      wr_req_addr  = 3'd1;
      wr_req_data  = 8'h11;
      rd_req_addr  = 3'd1;
      wr_req_valid = 1'b1;
      rd_req_valid = 1'b1;
      exp_wr = 1'b1;
      g = 0;
      for (int i = 0; i < 40 && g < 4; i++) begin
         acc_wr = 1'b0;
         @(negedge clk);
         if (wr_req_ready || rd_req_ready) begin
            check("t3_grant_wr", {31'd0, wr_req_ready}, {31'd0, exp_wr});
            check("t3_grant_rd", {31'd0, rd_req_ready}, {31'd0, !exp_wr});
            if (wr_req_ready) begin
               written[1]   = 1'b1;
               model_mem[1] = wr_req_data;
               acc_wr       = 1'b1;
            end else begin
               exp_q.push_back(model_rsp(3'd1));
            end
            exp_wr = !exp_wr;
            g++;
         end
         @(posedge clk);
         #1;
         if (acc_wr) wr_req_data = wr_req_data + 8'h11;
      end
      wr_req_valid = 1'b0;
      rd_req_valid = 1'b0;
      check("t3_grants", g, 32'd4);
      idle_cycles(4);

      // 4: response held under back-pressure, requests blocked
      rd_rsp_ready = 1'b0;
      issue_rd(3'd3, 1'b1);
      wr_req_valid = 1'b1;
      rd_req_valid = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t4_rsp_valid", {31'd0, rd_rsp_valid}, 32'd1);
         check("t4_rsp_data", {24'd0, rd_rsp_data}, 32'hA5);
         check("t4_rsp_err", {31'd0, rd_rsp_err}, 32'd0);
         check("t4_readies", {30'd0, wr_req_ready, rd_req_ready}, 32'd0);
         check("t4_busy", {31'd0, busy}, 32'd1);
      end
      @(posedge clk);
      #1;
      wr_req_valid = 1'b0;
      rd_req_valid = 1'b0;
      rd_rsp_ready = 1'b1;
      idle_cycles(3);

      // 5: reset during ISSUE_RD drops the read and clears valid_map
      issue_rd(3'd3, 1'b0);
      #2;
      check("t5_rd_strobe_pre", {31'd0, ffa_rd}, 32'd1);
      resetn = 1'b0;
      wr_req_valid = 1'b1;
      #1;
      check("t5_rd_strobe_rst", {31'd0, ffa_rd}, 32'd0);
      check("t5_busy_rst", {31'd0, busy}, 32'd0);
      check("t5_addr_rst", {29'd0, ffa_addr}, 32'd0);
      check("t5_wr_ready_rst", {31'd0, wr_req_ready}, 32'd0);
      for (int j = 0; j < DATA_N; j++) written[j] = 1'b0;
      wr_req_valid = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t5_no_rsp", {31'd0, rd_rsp_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      issue_rd(3'd3, 1'b1);
      idle_cycles(4);

      // 6: array error on a written address
      issue_wr(3'd2, 8'h5C);
      idle_cycles(2);
      force_err = 1'b1;
      issue_rd(3'd2, 1'b1);
      idle_cycles(4);
      force_err = 1'b0;

      // Rewrite of the same address is legal and the new value is returned.
      issue_wr(3'd7, 8'h3C);
      idle_cycles(1);
      issue_wr(3'd7, 8'hC3);
      idle_cycles(1);
      issue_rd(3'd7, 1'b1);
      idle_cycles(4);
      issue_rd(3'd2, 1'b1);
      idle_cycles(4);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
